// File: rtl/mips_uart_pkg.sv
// Shared types and constants for the PortOut UART transmitter.
// Parity support is selected by the MIPS_UART_PARITY_EN macro in the top module.
package mips_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam int DATA_BITS = 8;

    // Layout of the PortIn status byte
    localparam int STAT_OVF_BIT  = 7;
    localparam int STAT_FULL_BIT = 6;
    localparam int STAT_BUSY_BIT = 5;
    localparam int STAT_CNT_MSB  = 4;
    localparam int STAT_CNT_LSB  = 0;

    function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/mips_port_uart_fifo.sv
// Small synchronous FIFO buffering bytes between the processor port and the serialiser.
// Push while full and pop while empty are ignored; pointers wrap modulo FIFO_DEPTH.
module port_fifo #(
    parameter int FIFO_DEPTH = 4,
    parameter int WIDTH      = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push,
    input  logic                          pop,
    input  logic [WIDTH-1:0]              din,
    output logic [WIDTH-1:0]              dout,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          full,
    output logic                          empty
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(FIFO_DEPTH);

    logic [WIDTH-1:0] mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full  = (count_r == CNT_DEPTH);
    assign empty = (count_r == {CNT_W{1'b0}});
    assign count = count_r;
    assign dout  = mem_r[rd_ptr_r];

    // Qualify requests against the current fill level
    always_comb begin
        do_push_s = push & ~full;
        do_pop_s  = pop & ~empty;
    end

    // Storage, pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= din;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/mips_port_uart_tx.sv
// UART transmitter fed from the processor PortOut path: FIFO plus 8N1 serialiser.
// Define MIPS_UART_PARITY_EN to insert an even-parity bit (8E1 frames).
module mips_port_uart_tx
    import mips_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [31:0] wr_data,
    output logic        tx,
    output logic        busy,
    output logic        full,
    output logic        overflow,
    input  logic        ovf_clr,
    output logic [7:0]  status
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
    localparam logic [2:0]        LAST_BIT  = 3'(DATA_BITS - 1);

    uart_state_e            state_r;
    logic [BAUD_W-1:0]      baud_r;
    logic [2:0]             bit_idx_r;
    logic [DATA_BITS-1:0]   shift_r;
    logic                   tx_r;
    logic                   overflow_r;
    logic [7:0]             status_r;
`ifdef MIPS_UART_PARITY_EN
    logic                   parity_r;
`endif

    logic                   push_s;
    logic                   pop_s;
    logic                   busy_s;
    logic                   baud_last_s;
    logic [7:0]             status_s;
    logic [DATA_BITS-1:0]   fifo_dout_s;
    logic [CNT_W-1:0]       fifo_count_s;
    logic                   fifo_full_s;
    logic                   fifo_empty_s;
    logic                   unused_wr_data_s;

    assign unused_wr_data_s = ^wr_data[31:8];

    port_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .WIDTH      (DATA_BITS)
    ) u_fifo (
        .clk   (clk),
        .rst_n (reset),
        .push  (push_s),
        .pop   (pop_s),
        .din   (wr_data[7:0]),
        .dout  (fifo_dout_s),
        .count (fifo_count_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // FIFO handshakes and combinational status terms
    always_comb begin
        push_s      = wr_en & ~fifo_full_s;
        baud_last_s = (baud_r == BAUD_LAST);
        busy_s      = (state_r != ST_IDLE) | ~fifo_empty_s;
        if (state_r == ST_IDLE) begin
            pop_s = ~fifo_empty_s;
        end else if ((state_r == ST_STOP) && baud_last_s) begin
            pop_s = ~fifo_empty_s;
        end else begin
            pop_s = 1'b0;
        end
    end

    // Status byte assembly for the PortIn read-back
    always_comb begin
        status_s                              = 8'h00;
        status_s[STAT_OVF_BIT]                = overflow_r;
        status_s[STAT_FULL_BIT]               = fifo_full_s;
        status_s[STAT_BUSY_BIT]               = busy_s;
        status_s[STAT_CNT_MSB:STAT_CNT_LSB]   = 5'(fifo_count_s);
    end

    // Frame sequencer; tx is registered from the current state, so the line lags state by one cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= ST_IDLE;
            baud_r    <= {BAUD_W{1'b0}};
            bit_idx_r <= 3'd0;
            shift_r   <= {DATA_BITS{1'b0}};
            tx_r      <= 1'b1;
`ifdef MIPS_UART_PARITY_EN
            parity_r  <= 1'b0;
`endif
        end else begin
            case (state_r)
                ST_IDLE: begin
                    tx_r   <= 1'b1;
                    baud_r <= {BAUD_W{1'b0}};
                    if (!fifo_empty_s) begin
                        shift_r  <= fifo_dout_s;
`ifdef MIPS_UART_PARITY_EN
                        parity_r <= even_parity(fifo_dout_s);
`endif
                        state_r  <= ST_START;
                    end else begin
                        state_r  <= ST_IDLE;
                    end
                end
                ST_START: begin
                    tx_r <= 1'b0;
                    if (baud_last_s) begin
                        baud_r    <= {BAUD_W{1'b0}};
                        bit_idx_r <= 3'd0;
                        state_r   <= ST_DATA;
                    end else begin
                        baud_r    <= baud_r + BAUD_ONE;
                    end
                end
                ST_DATA: begin
                    tx_r <= shift_r[0];
                    if (baud_last_s) begin
                        baud_r  <= {BAUD_W{1'b0}};
                        shift_r <= shift_r >> 1;
                        if (bit_idx_r == LAST_BIT) begin
`ifdef MIPS_UART_PARITY_EN
                            state_r <= ST_PARITY;
`else
                            state_r <= ST_STOP;
`endif
                        end else begin
                            bit_idx_r <= bit_idx_r + 3'd1;
                        end
                    end else begin
                        baud_r <= baud_r + BAUD_ONE;
                    end
                end
`ifdef MIPS_UART_PARITY_EN
                ST_PARITY: begin
                    tx_r <= parity_r;
                    if (baud_last_s) begin
                        baud_r  <= {BAUD_W{1'b0}};
                        state_r <= ST_STOP;
                    end else begin
                        baud_r  <= baud_r + BAUD_ONE;
                    end
                end
`endif
                ST_STOP: begin
                    tx_r <= 1'b1;
                    if (baud_last_s) begin
                        baud_r <= {BAUD_W{1'b0}};
                        // Chain straight into the next frame when data is waiting
                        if (!fifo_empty_s) begin
                            shift_r  <= fifo_dout_s;
`ifdef MIPS_UART_PARITY_EN
                            parity_r <= even_parity(fifo_dout_s);
`endif
                            state_r  <= ST_START;
                        end else begin
                            state_r  <= ST_IDLE;
                        end
                    end else begin
                        baud_r <= baud_r + BAUD_ONE;
                    end
                end
                default: begin
                    tx_r    <= 1'b1;
                    baud_r  <= {BAUD_W{1'b0}};
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Sticky overflow: a dropped write wins over a same-cycle clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow_r <= 1'b0;
        end else if (wr_en && fifo_full_s) begin
            overflow_r <= 1'b1;
        end else if (ovf_clr) begin
            overflow_r <= 1'b0;
        end else begin
            overflow_r <= overflow_r;
        end
    end

    // Registered status byte
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            status_r <= 8'h00;
        end else begin
            status_r <= status_s;
        end
    end

    assign tx       = tx_r;
    assign busy     = busy_s;
    assign full     = fifo_full_s;
    assign overflow = overflow_r;
    assign status   = status_r;

endmodule

// File: tb/tb_mips_port_uart_tx.sv
// Directed bench for mips_port_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// The parity scenario is compiled only when MIPS_UART_PARITY_EN is defined.
module tb_mips_port_uart_tx;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] wr_data = 32'h0;
    logic        ovf_clr = 1'b0;
    logic        tx;
    logic        busy;
    logic        full;
    logic        overflow;
    logic [7:0]  status;

    int checks = 0;
    int errors = 0;
    logic txlog[$];

    mips_port_uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .tx       (tx),
        .busy     (busy),
        .full     (full),
        .overflow (overflow),
        .ovf_clr  (ovf_clr),
        .status   (status)
    );

    always #5 clk = ~clk;

    // Advance one edge and sample 1 time unit later
    task automatic step();
        @(posedge clk);
        #1;
        txlog.push_back(tx);
    endtask

    // Record nbits bit periods (4 cycles each); stable clears if any bit wobbles
    task automatic capture(input int nbits, output logic [10:0] bits, output bit stable);
        bits = 11'h0;
        stable = 1'b1;
        for (int b = 0; b < nbits; b++) begin
            for (int c = 0; c < 4; c++) begin
                step();
                if (c == 0) bits[b] = tx;
                else if (tx !== bits[b]) stable = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) step();
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx got %b want 1", tx); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", full); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", overflow); end
        checks++; if (status !== 8'h00) begin errors++; $display("FAIL reset_status got %h want 00", status); end
        reset = 1'b1;
        repeat (2) step();
    endtask

    task automatic test_single();
        logic [10:0] bits;
        bit stable;
        wr_data = 32'hDEADBEA5; wr_en = 1'b1;
        step();
        wr_en = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b want 1", busy); end
        step();
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL single_latency_tx got %b want 1", tx); end
        checks++; if (status !== 8'h21) begin errors++; $display("FAIL single_status got %h want 21", status); end
        capture(10, bits, stable);
        checks++; if (bits[9:0] !== 10'b1101001010) begin errors++; $display("FAIL single_frame got %b want 1101001010", bits[9:0]); end
        checks++; if (stable !== 1'b1) begin errors++; $display("FAIL single_bit_width got %b want 1", stable); end
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end got %b want 0", busy); end
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL single_idle_tx got %b want 1", tx); end
    endtask

    task automatic test_back_to_back();
        logic [10:0] b0;
        logic [10:0] b1;
        bit s0;
        bit s1;
        wr_data = 32'h00000055; wr_en = 1'b1;
        step();
        wr_data = 32'h0000000F;
        step();
        wr_en = 1'b0;
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL b2b_latency_tx got %b want 1", tx); end
        capture(10, b0, s0);
        capture(10, b1, s1);
        checks++; if (b0[9:0] !== 10'b1010101010) begin errors++; $display("FAIL b2b_frame0 got %b want 1010101010", b0[9:0]); end
        checks++; if (b1[9:0] !== 10'b1000011110) begin errors++; $display("FAIL b2b_frame1 got %b want 1000011110", b1[9:0]); end
        checks++; if ((s0 & s1) !== 1'b1) begin errors++; $display("FAIL b2b_bit_width got %b want 1", s0 & s1); end
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_end got %b want 0", busy); end
    endtask

    task automatic test_overflow();
        logic [7:0] want [5];
        logic [7:0] got;
        int starts[$];
        int budget;
        int i;
        want = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        txlog.delete();
        for (int k = 0; k < 6; k++) begin
            wr_data = 32'(8'h11 * (k + 1)); wr_en = 1'b1;
            step();
            if (k == 3) begin
                checks++; if (full !== 1'b0) begin errors++; $display("FAIL ovf_full_k3 got %b want 0", full); end
            end
            if (k == 4) begin
                checks++; if (full !== 1'b1) begin errors++; $display("FAIL ovf_full_k4 got %b want 1", full); end
            end
        end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %b want 1", overflow); end
        wr_data = 32'h77; ovf_clr = 1'b1;
        step();
        wr_en = 1'b0;
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set_wins got %b want 1", overflow); end
        step();
        ovf_clr = 1'b0;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b want 0", overflow); end
        step();
        checks++; if (status !== 8'h64) begin errors++; $display("FAIL ovf_status got %h want 64", status); end
        budget = 400;
        while (busy === 1'b1 && budget > 0) begin step(); budget--; end
        checks++; if (budget == 0) begin errors++; $display("FAIL ovf_drain_timeout got busy=%b want 0", busy); end
        repeat (10) step();
        i = 0;
        while (i + 40 <= txlog.size()) begin
            if (txlog[i] == 1'b0) begin
                for (int b = 0; b < 8; b++) got[b] = txlog[i + 4 * b + 6];
                if (starts.size() < 5) begin
                    checks++;
                    if (got !== want[starts.size()]) begin
                        errors++; $display("FAIL ovf_byte%0d got %h want %h", starts.size(), got, want[starts.size()]);
                    end
                end
                checks++; if (txlog[i + 38] !== 1'b1) begin errors++; $display("FAIL ovf_stop%0d got %b want 1", starts.size(), txlog[i + 38]); end
                starts.push_back(i);
                i += 40;
            end else begin
                i++;
            end
        end
        checks++; if (starts.size() != 5) begin errors++; $display("FAIL ovf_frames got %0d want 5", starts.size()); end
        for (int k = 1; k < starts.size(); k++) begin
            checks++;
            if (starts[k] != starts[0] + 40 * k) begin
                errors++; $display("FAIL ovf_gap%0d got %0d want %0d", k, starts[k], starts[0] + 40 * k);
            end
        end
    endtask

    task automatic test_reset_midframe();
        bit quiet;
        wr_data = 32'hF0; wr_en = 1'b1;
        step();
        wr_data = 32'h0F;
        step();
        wr_en = 1'b0;
        repeat (17) step();
        checks++; if (tx !== 1'b0) begin errors++; $display("FAIL mid_pre_tx got %b want 0", tx); end
        reset = 1'b0;
        #1;
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL mid_async_tx got %b want 1", tx); end
        checks++; if (status !== 8'h00) begin errors++; $display("FAIL mid_async_status got %h want 00", status); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_async_busy got %b want 0", busy); end
        repeat (2) step();
        reset = 1'b1;
        quiet = 1'b1;
        for (int k = 0; k < 60; k++) begin
            step();
            if (tx !== 1'b1 || busy !== 1'b0) quiet = 1'b0;
        end
        checks++; if (quiet !== 1'b1) begin errors++; $display("FAIL mid_no_residual got %b want 1", quiet); end
    endtask

`ifdef MIPS_UART_PARITY_EN
    task automatic test_parity();
        logic [10:0] bits;
        bit stable;
        wr_data = 32'h07; wr_en = 1'b1;
        step();
        wr_en = 1'b0;
        step();
        capture(11, bits, stable);
        checks++; if (bits !== 11'b11000001110) begin errors++; $display("FAIL par_07 got %b want 11000001110", bits); end
        step();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL par_len got busy=%b want 0", busy); end
        wr_data = 32'h03; wr_en = 1'b1;
        step();
        wr_en = 1'b0;
        step();
        capture(11, bits, stable);
        checks++; if (bits !== 11'b10000000110) begin errors++; $display("FAIL par_03 got %b want 10000000110", bits); end
        checks++; if (stable !== 1'b1) begin errors++; $display("FAIL par_bit_width got %b want 1", stable); end
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_reset_midframe();
`ifdef MIPS_UART_PARITY_EN
        test_parity();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
